// File: rtl/ysyx_25040101_wbu.sv
// ysyx_25040101_wbu -- write-back unit of the ysyx_25040101 multi-cycle core.
//
// Accepts one retiring instruction from EXU (valid/ready). For loads it waits for
// the LSU read response and extends the data. It then writes the register file for
// one cycle and pulses a commit strobe to the IFU.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   exu_valid_i / exu_ready_o  EXU handshake (ready only in IDLE)
//   wb_sel_i                   0 ALU, 1 load, 2 PC+4, 3 CSR, 4..7 no write-back
//   alu_result_i, pc_i, csr_rdata_i, rd_addr_i, rd_wen_i   instruction payload
//   load_type_i, addr_lo_i     load width/sign and byte offset
//   lsu_rvalid_i / lsu_rready_o, lsu_rdata_i, lsu_rerr_i   LSU read response
//   rf_wen_o, rf_waddr_o, rf_wdata_o   register-file write port
//   commit_o, load_err_o       retire strobe and faulted-load strobe
module ysyx_25040101_wbu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exu_valid_i,
  output logic        exu_ready_o,
  input  logic [2:0]  wb_sel_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] csr_rdata_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        rd_wen_i,
  input  logic [2:0]  load_type_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        lsu_rvalid_i,
  output logic        lsu_rready_o,
  input  logic [31:0] lsu_rdata_i,
  input  logic        lsu_rerr_i,
  output logic        rf_wen_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        commit_o,
  output logic        load_err_o
);

  typedef enum logic [1:0] {StIdle, StWaitLd, StCommit} state_e;

  state_e      state_q, state_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wen_q, wen_d;
  logic        nowb_q, nowb_d;
  logic        err_q, err_d;
  logic [2:0]  ltype_q, ltype_d;
  logic [1:0]  alo_q, alo_d;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] wb_val;

  // Load extension uses the latched type/offset and the live response word.
  always_comb begin
    ld_byte = 8'h00;
    case (alo_q)
      2'd0:    ld_byte = lsu_rdata_i[7:0];
      2'd1:    ld_byte = lsu_rdata_i[15:8];
      2'd2:    ld_byte = lsu_rdata_i[23:16];
      default: ld_byte = lsu_rdata_i[31:24];
    endcase
    // Bit 0 of the offset is ignored for halfwords; alignment is checked upstream.
    ld_half = alo_q[1] ? lsu_rdata_i[31:16] : lsu_rdata_i[15:0];
    ld_ext  = lsu_rdata_i;
    case (ltype_q)
      3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_ext = {24'h000000, ld_byte};
      3'd5:    ld_ext = {16'h0000, ld_half};
      default: ld_ext = lsu_rdata_i;
    endcase
  end

  // Non-load write-back value, computed at accept time.
  always_comb begin
    wb_val = alu_result_i;
    case (wb_sel_i)
      3'd2:    wb_val = pc_i + 32'd4;
      3'd3:    wb_val = csr_rdata_i;
      default: wb_val = alu_result_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wen_d   = wen_q;
    nowb_d  = nowb_q;
    err_d   = err_q;
    ltype_d = ltype_q;
    alo_d   = alo_q;
    case (state_q)
      StIdle: begin
        if (exu_valid_i) begin
          waddr_d = rd_addr_i;
          wen_d   = rd_wen_i;
          nowb_d  = (wb_sel_i >= 3'd4);
          err_d   = 1'b0;
          ltype_d = load_type_i;
          alo_d   = addr_lo_i;
          if (wb_sel_i == 3'd1) begin
            state_d = StWaitLd;
          end else begin
            wdata_d = wb_val;
            state_d = StCommit;
          end
        end
      end
      StWaitLd: begin
        if (lsu_rvalid_i) begin
          wdata_d = ld_ext;
          err_d   = lsu_rerr_i;
          state_d = StCommit;
        end
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
      wen_q   <= 1'b0;
      nowb_q  <= 1'b0;
      err_q   <= 1'b0;
      ltype_q <= 3'd0;
      alo_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      nowb_q  <= nowb_d;
      err_q   <= err_d;
      ltype_q <= ltype_d;
      alo_q   <= alo_d;
    end
  end

  // All handshake/strobe outputs decode registered state only.
  assign exu_ready_o  = (state_q == StIdle);
  assign lsu_rready_o = (state_q == StWaitLd);
  assign commit_o     = (state_q == StCommit);
  assign load_err_o   = commit_o & err_q;
  assign rf_wen_o     = commit_o & wen_q & (waddr_q != 5'd0) & ~nowb_q & ~err_q;
  assign rf_waddr_o   = waddr_q;
  assign rf_wdata_o   = wdata_q;

endmodule

// File: tb/tb_ysyx_25040101_wbu.sv
// Directed testbench for ysyx_25040101_wbu. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_ysyx_25040101_wbu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exu_valid_i;
  logic        exu_ready_o;
  logic [2:0]  wb_sel_i;
  logic [31:0] alu_result_i;
  logic [31:0] pc_i;
  logic [31:0] csr_rdata_i;
  logic [4:0]  rd_addr_i;
  logic        rd_wen_i;
  logic [2:0]  load_type_i;
  logic [1:0]  addr_lo_i;
  logic        lsu_rvalid_i;
  logic        lsu_rready_o;
  logic [31:0] lsu_rdata_i;
  logic        lsu_rerr_i;
  logic        rf_wen_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        commit_o;
  logic        load_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_25040101_wbu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .exu_valid_i  (exu_valid_i),
    .exu_ready_o  (exu_ready_o),
    .wb_sel_i     (wb_sel_i),
    .alu_result_i (alu_result_i),
    .pc_i         (pc_i),
    .csr_rdata_i  (csr_rdata_i),
    .rd_addr_i    (rd_addr_i),
    .rd_wen_i     (rd_wen_i),
    .load_type_i  (load_type_i),
    .addr_lo_i    (addr_lo_i),
    .lsu_rvalid_i (lsu_rvalid_i),
    .lsu_rready_o (lsu_rready_o),
    .lsu_rdata_i  (lsu_rdata_i),
    .lsu_rerr_i   (lsu_rerr_i),
    .rf_wen_o     (rf_wen_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o),
    .commit_o     (commit_o),
    .load_err_o   (load_err_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one instruction; returns at the falling edge after the accept edge.
  task automatic issue(input logic [2:0] sel, input logic [31:0] alu, input logic [31:0] pc,
                       input logic [31:0] csr, input logic [4:0] rd, input logic wen,
                       input logic [2:0] lt, input logic [1:0] a);
    check_eq("ready_before_issue", {31'd0, exu_ready_o}, 32'd1);
    wb_sel_i = sel; alu_result_i = alu; pc_i = pc; csr_rdata_i = csr;
    rd_addr_i = rd; rd_wen_i = wen; load_type_i = lt; addr_lo_i = a;
    exu_valid_i = 1'b1;
    @(negedge clk);
    exu_valid_i = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [2:0] sel, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [31:0] csr, input logic [4:0] rd,
                       input logic wen, input logic exp_wen, input logic [31:0] exp_data);
    issue(sel, alu, pc, csr, rd, wen, 3'd2, 2'd0);
    check_eq({tag, "_commit"}, {31'd0, commit_o}, 32'd1);
    check_eq({tag, "_wen"}, {31'd0, rf_wen_o}, {31'd0, exp_wen});
    if (exp_wen) begin
      check_eq({tag, "_waddr"}, {27'd0, rf_waddr_o}, {27'd0, rd});
      check_eq({tag, "_wdata"}, rf_wdata_o, exp_data);
    end
    @(negedge clk);
    check_eq({tag, "_commit_drop"}, {31'd0, commit_o}, 32'd0);
    check_eq({tag, "_wen_drop"}, {31'd0, rf_wen_o}, 32'd0);
    check_eq({tag, "_ready_back"}, {31'd0, exu_ready_o}, 32'd1);
  endtask

  task automatic do_load(input string tag, input logic [2:0] lt, input logic [1:0] a,
                         input logic [31:0] rdata, input int dly, input logic err,
                         input logic [4:0] rd, input logic exp_wen,
                         input logic [31:0] exp_data);
    issue(3'd1, 32'hA5A5A5A5, 32'h0, 32'h0, rd, 1'b1, lt, a);
    check_eq({tag, "_rready"}, {31'd0, lsu_rready_o}, 32'd1);
    check_eq({tag, "_no_early_commit"}, {31'd0, commit_o}, 32'd0);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check_eq({tag, "_wait_commit"}, {31'd0, commit_o}, 32'd0);
      check_eq({tag, "_wait_rready"}, {31'd0, lsu_rready_o}, 32'd1);
    end
    lsu_rvalid_i = 1'b1; lsu_rdata_i = rdata; lsu_rerr_i = err;
    @(negedge clk);
    lsu_rvalid_i = 1'b0; lsu_rerr_i = 1'b0; lsu_rdata_i = 32'h0;
    check_eq({tag, "_commit"}, {31'd0, commit_o}, 32'd1);
    check_eq({tag, "_wen"}, {31'd0, rf_wen_o}, {31'd0, exp_wen});
    check_eq({tag, "_lerr"}, {31'd0, load_err_o}, {31'd0, err});
    if (exp_wen) begin
      check_eq({tag, "_waddr"}, {27'd0, rf_waddr_o}, {27'd0, rd});
      check_eq({tag, "_wdata"}, rf_wdata_o, exp_data);
    end
    @(negedge clk);
    check_eq({tag, "_commit_drop"}, {31'd0, commit_o}, 32'd0);
    check_eq({tag, "_lerr_drop"}, {31'd0, load_err_o}, 32'd0);
    check_eq({tag, "_ready_back"}, {31'd0, exu_ready_o}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; exu_valid_i = 1'b0; wb_sel_i = 3'd0; alu_result_i = 32'h0;
    pc_i = 32'h0; csr_rdata_i = 32'h0; rd_addr_i = 5'd0; rd_wen_i = 1'b0;
    load_type_i = 3'd0; addr_lo_i = 2'd0; lsu_rvalid_i = 1'b0; lsu_rdata_i = 32'h0;
    lsu_rerr_i = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", {31'd0, exu_ready_o}, 32'd1);
    check_eq("rst_rready", {31'd0, lsu_rready_o}, 32'd0);
    check_eq("rst_commit", {31'd0, commit_o}, 32'd0);
    check_eq("rst_wen", {31'd0, rf_wen_o}, 32'd0);
    check_eq("rst_lerr", {31'd0, load_err_o}, 32'd0);
    check_eq("rst_waddr", {27'd0, rf_waddr_o}, 32'd0);
    check_eq("rst_wdata", rf_wdata_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("alu", 3'd0, 32'h12345678, 32'h0, 32'h0, 5'd5, 1'b1, 1'b1, 32'h12345678);
    do_op("x0", 3'd0, 32'h11111111, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 32'h0);
    do_op("nowb", 3'd4, 32'h22222222, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0, 32'h0);
    do_op("sel7", 3'd7, 32'h33333333, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0, 32'h0);
    do_op("nowen", 3'd0, 32'h44444444, 32'h0, 32'h0, 5'd8, 1'b0, 1'b0, 32'h0);
    do_op("pc4wrap", 3'd2, 32'h55555555, 32'hFFFFFFFC, 32'h0, 5'd1, 1'b1, 1'b1, 32'h0);
    do_op("pc4", 3'd2, 32'h0, 32'h80000010, 32'h0, 5'd2, 1'b1, 1'b1, 32'h80000014);
    do_op("csr", 3'd3, 32'h0, 32'h0, 32'hDEADBEEF, 5'd31, 1'b1, 1'b1, 32'hDEADBEEF);

    do_load("lb_a2", 3'd0, 2'd2, 32'h80FF7F01, 0, 1'b0, 5'd10, 1'b1, 32'hFFFFFFFF);
    do_load("lbu_a3", 3'd4, 2'd3, 32'h80FF7F01, 1, 1'b0, 5'd11, 1'b1, 32'h00000080);
    do_load("lh_a2", 3'd1, 2'd2, 32'h80FF7F01, 5, 1'b0, 5'd12, 1'b1, 32'hFFFF80FF);
    do_load("lhu_a0", 3'd5, 2'd0, 32'h80FF7F01, 0, 1'b0, 5'd13, 1'b1, 32'h00007F01);
    do_load("lw", 3'd2, 2'd1, 32'h80FF7F01, 1, 1'b0, 5'd14, 1'b1, 32'h80FF7F01);
    do_load("lb_a1", 3'd0, 2'd1, 32'h80FF7F01, 0, 1'b0, 5'd15, 1'b1, 32'h0000007F);
    do_load("lh_a0", 3'd1, 2'd0, 32'h12348765, 0, 1'b0, 5'd16, 1'b1, 32'hFFFF8765);
    do_load("lt3_word", 3'd3, 2'd2, 32'hCAFEF00D, 0, 1'b0, 5'd17, 1'b1, 32'hCAFEF00D);
    do_load("ld_x0", 3'd2, 2'd0, 32'h99999999, 0, 1'b0, 5'd0, 1'b0, 32'h0);
    do_load("ldfault", 3'd2, 2'd0, 32'h12345678, 2, 1'b1, 5'd9, 1'b0, 32'h0);

    // Reset while waiting for load data; the response arrives during and after reset.
    issue(3'd1, 32'h0, 32'h0, 32'h0, 5'd20, 1'b1, 3'd2, 2'd0);
    check_eq("rstld_rready", {31'd0, lsu_rready_o}, 32'd1);
    rst_n = 1'b0; lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h77777777;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rstld_ready", {31'd0, exu_ready_o}, 32'd1);
    check_eq("rstld_rready_low", {31'd0, lsu_rready_o}, 32'd0);
    check_eq("rstld_commit", {31'd0, commit_o}, 32'd0);
    check_eq("rstld_waddr", {27'd0, rf_waddr_o}, 32'd0);
    check_eq("rstld_wdata", rf_wdata_o, 32'd0);
    @(negedge clk);
    lsu_rvalid_i = 1'b0;
    check_eq("stray_commit", {31'd0, commit_o}, 32'd0);
    check_eq("stray_wen", {31'd0, rf_wen_o}, 32'd0);
    check_eq("stray_rready", {31'd0, lsu_rready_o}, 32'd0);
    check_eq("stray_ready", {31'd0, exu_ready_o}, 32'd1);
    check_eq("stray_wdata", rf_wdata_o, 32'd0);

    // Back-to-back operation still works afterwards.
    do_op("alu2", 3'd0, 32'h0BADF00D, 32'h0, 32'h0, 5'd3, 1'b1, 1'b1, 32'h0BADF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
